// File: rtl/stumps_misr_unloader.sv
// ---------------------------------------------------------------------------
// stumps_misr_unloader
//
// Scan-unload end of a STUMPS self-test path. Sequences the shift/capture
// windows of a bank of scan chains through TC and compacts their parallel
// scan-out bits into a multiple-input signature register (MISR). At the end
// of a session the final signature is compared against GOLDEN.
//
// Session shape: LOAD (CHAIN_LEN) then PATTERNS x { CAPTURE (1), UNLOAD
// (CHAIN_LEN) }. Unloading pattern k overlaps loading pattern k+1, so the
// UNLOAD window doubles as the next LOAD.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-low
//   start      begin a session; honoured only in IDLE or DONE
//   SO         scan-out bit of each chain (chain i on SO[i])
//   TC         test control to chains: 1 = shift, 0 = capture/functional
//   busy       session in progress
//   done       session complete; level, held until next start
//   pass       signature == GOLDEN; valid while done=1, else 0
//   signature  current MISR contents
// ---------------------------------------------------------------------------
module stumps_misr_unloader #(
    parameter int           CHAINS    = 4,
    parameter int           CHAIN_LEN = 8,
    parameter int           PATTERNS  = 2,
    parameter int           W         = 16,
    parameter logic [W-1:0] POLY      = 16'h1021,
    parameter logic [W-1:0] SEED      = 16'h0000,
    parameter logic [W-1:0] GOLDEN    = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CHAINS-1:0] SO,
    output logic              TC,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [W-1:0]      signature
);

    localparam int SW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam int PW = (PATTERNS > 0) ? $clog2(PATTERNS + 1) : 1;

    localparam logic [SW-1:0] SHIFT_LAST = SW'(CHAIN_LEN - 1);
    localparam logic [PW-1:0] PAT_LAST   = PW'(PATTERNS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CAPTURE,
        S_UNLOAD,
        S_DONE
    } state_t;

    state_t         state, state_nxt;
    logic [SW-1:0]  shift_cnt, shift_nxt;
    logic [PW-1:0]  pat_cnt, pat_nxt;
    logic [W-1:0]   sig_nxt;
    logic           done_nxt, pass_nxt;

    // One MISR clock: shift left, fold the MSB back through POLY, then
    // XOR in the zero-extended chain outputs.
    function automatic logic [W-1:0] misr_step(input logic [W-1:0]      m,
                                               input logic [CHAINS-1:0] so);
        logic [W-1:0] so_ext;
        so_ext             = '0;
        so_ext[CHAINS-1:0] = so;
        return {m[W-2:0], 1'b0} ^ (m[W-1] ? POLY : '0) ^ so_ext;
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Counters, signature and result flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_cnt <= '0;
            pat_cnt   <= '0;
            signature <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            shift_cnt <= shift_nxt;
            pat_cnt   <= pat_nxt;
            signature <= sig_nxt;
            done      <= done_nxt;
            pass      <= pass_nxt;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_nxt = state;
        shift_nxt = shift_cnt;
        pat_nxt   = pat_cnt;
        sig_nxt   = signature;
        done_nxt  = done;
        pass_nxt  = pass;
        TC        = 1'b0;
        busy      = 1'b0;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    sig_nxt   = SEED;
                    shift_nxt = '0;
                    pat_nxt   = '0;
                    done_nxt  = 1'b0;
                    pass_nxt  = 1'b0;
                    state_nxt = S_LOAD;
                end
            end

            // First fill of the chains: nothing valid on SO yet, MISR holds.
            S_LOAD: begin
                TC   = 1'b1;
                busy = 1'b1;
                if (shift_cnt == SHIFT_LAST) begin
                    shift_nxt = '0;
                    state_nxt = S_CAPTURE;
                end else begin
                    shift_nxt = shift_cnt + SW'(1);
                end
            end

            S_CAPTURE: begin
                busy      = 1'b1;
                pat_nxt   = pat_cnt + PW'(1);
                state_nxt = S_UNLOAD;
            end

            S_UNLOAD: begin
                TC      = 1'b1;
                busy    = 1'b1;
                sig_nxt = misr_step(signature, SO);
                if (shift_cnt == SHIFT_LAST) begin
                    shift_nxt = '0;
                    if (pat_cnt == PAT_LAST) begin
                        // Judge the signature including this final compaction.
                        state_nxt = S_DONE;
                        done_nxt  = 1'b1;
                        pass_nxt  = (sig_nxt == GOLDEN);
                    end else begin
                        state_nxt = S_CAPTURE;
                    end
                end else begin
                    shift_nxt = shift_cnt + SW'(1);
                end
            end

            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_stumps_misr_unloader.sv
// ---------------------------------------------------------------------------
// tb_stumps_misr_unloader
//
// Self-checking bench for stumps_misr_unloader with default parameters.
// The reference model describes a session as a numbered list of busy
// cycles: cycle b < CHAIN_LEN is the initial load, after that every
// (CHAIN_LEN+1)-cycle group starts with one capture cycle followed by
// CHAIN_LEN unload cycles. The expected signature is folded from the SO
// values applied on unload cycles using the MISR recurrence.
// ---------------------------------------------------------------------------
module tb_stumps_misr_unloader;

    localparam int          CHAINS    = 4;
    localparam int          CHAIN_LEN = 8;
    localparam int          PATTERNS  = 2;
    localparam int          W         = 16;
    localparam logic [15:0] POLY      = 16'h1021;
    localparam logic [15:0] SEED      = 16'h0000;
    localparam logic [15:0] GOLDEN    = 16'h0000;
    localparam int          BUSY_CYC  = CHAIN_LEN * (PATTERNS + 1) + PATTERNS;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [CHAINS-1:0] SO;
    logic              TC, busy, done, pass;
    logic [W-1:0]      signature;

    int vectors     = 0;
    int miscompares = 0;

    stumps_misr_unloader #(
        .CHAINS(CHAINS), .CHAIN_LEN(CHAIN_LEN), .PATTERNS(PATTERNS), .W(W),
        .POLY(POLY), .SEED(SEED), .GOLDEN(GOLDEN)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .SO(SO),
        .TC(TC), .busy(busy), .done(done), .pass(pass), .signature(signature)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_compact(input logic [15:0] m, input logic [3:0] so);
        logic [15:0] r;
        r = m << 1;
        if (m[15]) r = r ^ POLY;
        return r ^ {12'h000, so};
    endfunction

    function automatic bit is_capture(input int b);
        return (b >= CHAIN_LEN) && (((b - CHAIN_LEN) % (CHAIN_LEN + 1)) == 0);
    endfunction

    function automatic bit is_unload(input int b);
        return (b >= CHAIN_LEN) && !is_capture(b);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_tc"},   TC,        0);
        chk({tag, "_busy"}, busy,      0);
        chk({tag, "_done"}, done,      0);
        chk({tag, "_pass"}, pass,      0);
        chk({tag, "_sig"},  signature, 0);
    endtask

    // mode: 0 = SO zero, 1 = SO=F during first load only,
    //       2 = single impulse on first unload cycle, 3 = random SO
    task automatic run_session(input int mode, input bit late_start, input bit abort,
                               output logic [15:0] final_sig);
        logic [15:0] m;
        logic [3:0]  so_v;
        m         = SEED;
        final_sig = 'x;
        start = 1'b1;
        SO    = '0;
        step();
        start = 1'b0;
        chk("start_sig",  signature, SEED);
        chk("start_done", done, 0);
        chk("start_pass", pass, 0);
        for (int b = 0; b < BUSY_CYC; b++) begin
            case (mode)
                0:       so_v = 4'h0;
                1:       so_v = (b < CHAIN_LEN) ? 4'hF : 4'h0;
                2:       so_v = (b == CHAIN_LEN + 1) ? 4'h1 : 4'h0;
                default: so_v = 4'($urandom);
            endcase
            SO    = so_v;
            start = late_start && (b == 5);
            chk("tc",   TC,   !is_capture(b));
            chk("busy", busy, 1);
            chk("done", done, 0);
            if (abort && (b == CHAIN_LEN + CHAIN_LEN + 1)) begin
                #2 rst = 1'b0;
                #1;
                chk_quiet("abort");
                step();
                chk_quiet("abort_hold");
                rst   = 1'b1;
                SO    = '0;
                start = 1'b0;
                return;
            end
            if (is_unload(b)) m = model_compact(m, so_v);
            step();
        end
        start = 1'b0;
        SO    = '0;
        chk("end_busy", busy, 0);
        chk("end_tc",   TC,   0);
        chk("end_done", done, 1);
        chk("end_sig",  signature, m);
        chk("end_pass", pass, (m == GOLDEN));
        for (int i = 0; i < 2; i++) begin
            SO = 4'($urandom);
            step();
            chk("hold_done", done, 1);
            chk("hold_sig",  signature, m);
            chk("hold_busy", busy, 0);
        end
        SO        = '0;
        final_sig = m;
    endtask

    initial begin
        logic [15:0] fs;
        rst   = 1'b0;
        start = 1'b0;
        SO    = '0;
        repeat (3) step();
        chk_quiet("in_reset");
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_quiet("idle");
        end

        // Plain timing, all-zero SO
        run_session(0, 1'b0, 1'b0, fs);
        chk("zero_sig_abs", signature, 16'h0000);
        chk("zero_pass_abs", pass, 1);

        // SO activity during the first load must not reach the MISR
        run_session(1, 1'b0, 1'b0, fs);
        chk("mask_sig_abs", signature, 16'h0000);
        chk("mask_pass_abs", pass, 1);

        // Single impulse walks up to the MSB after 16 compactions
        run_session(2, 1'b0, 1'b0, fs);
        chk("impulse_sig_abs", signature, 16'h8000);
        chk("impulse_pass_abs", pass, 0);

        // Abort during second capture, then a clean session
        run_session(0, 1'b0, 1'b1, fs);
        step();
        chk_quiet("post_abort_idle");
        run_session(0, 1'b0, 1'b0, fs);
        chk("after_abort_pass", pass, 1);

        // Start while busy is ignored; following sessions restart from DONE
        run_session(0, 1'b1, 1'b0, fs);
        for (int s = 0; s < 5; s++) begin
            run_session(3, 1'($urandom), 1'b0, fs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
